ifetch_stage: RTL and testbench

- Instruction-fetch stage that drives one port of the team's dual-port SRAM in REAL mode, which has a registered read with 1-cycle latency.
- Generates the word address, captures returned read data, and tags each word with its PC.
- Buffers up to 2 instructions and presents them to decode over a valid/ready handshake.
- Accepts a PC redirect from execute (branch/jump) and discards stale fetches.

---
 rtl/ifetch_stage.sv | 98 +++++++++
 tb/tb_ifetch_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: issues word reads to a 1-cycle-latency SRAM port,
// tags returned words with their PC and queues them (2 deep) toward decode.
module ifetch_stage #(
  parameter int          N        = 16,
  parameter int          AW       = $clog2(N),
  parameter int          DW       = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_en,
  output logic          imem_wen,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  output logic [31:0]   out_pc,
  output logic [DW-1:0] out_instr,
  input  logic          out_ready
);

  typedef enum logic {BOOT, RUN} state_e;

  typedef struct packed {
    logic [31:0]   pc;
    logic [DW-1:0] instr;
  } ent_t;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        infl_q, infl_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] reqpc_q, reqpc_d;
  ent_t        ent_q [2];
  ent_t        ent_d [2];

  logic        pop, push, req, credit_ok, wr_idx;
  logic [31:0] tgt, req_pc;
  logic        unused_bits;

  assign out_valid = (cnt_q != 2'd0);
  assign out_pc    = ent_q[0].pc;
  assign out_instr = ent_q[0].instr;
  assign imem_wen  = 1'b0;

  always_comb begin
    pop       = out_valid & out_ready;
    tgt       = {redirect_pc[31:2], 2'b00};
    // Slots already owed (queued + in flight, less the one leaving) must leave room.
    credit_ok = ({1'b0, cnt_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    req       = redirect_valid | (state_q == BOOT) | credit_ok;
    req_pc    = redirect_valid ? tgt : fpc_q;
    // Data returning during a redirect belongs to the old stream; drop it.
    push      = infl_q & ~redirect_valid;
    wr_idx    = 1'(cnt_q - {1'b0, pop});

    state_d   = RUN;
    infl_d    = req;
    reqpc_d   = req ? req_pc : reqpc_q;
    fpc_d     = req ? req_pc + 32'd4 : fpc_q;
    ent_d     = ent_q;
    cnt_d     = cnt_q;

    if (redirect_valid) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) ent_d[0] = ent_q[1];
      if (push) ent_d[wr_idx] = '{pc: reqpc_q, instr: imem_rdata};
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign imem_en     = rst_n & req;
  assign imem_addr   = rst_n ? req_pc[AW+1:2] : '0;
  assign unused_bits = ^{redirect_pc[1:0], req_pc[31:AW+2], req_pc[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      cnt_q    <= 2'd0;
      infl_q   <= 1'b0;
      fpc_q    <= RESET_PC;
      reqpc_q  <= 32'h0;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      infl_q   <= infl_d;
      fpc_q    <= fpc_d;
      reqpc_q  <= reqpc_d;
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed cycle table, reset-mid-stream sequence,
// then random ready/redirect/reset traffic against a PC-stream model.
module tb_ifetch_stage;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_en, imem_wen;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata = '0;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic [31:0]   out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_stage #(.N(N), .AW(AW), .DW(DW), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_wen(imem_wen), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  // Memory word k holds 0x1000+k; registered read, holds dout when disabled.
  always @(posedge clk) if (imem_en) imem_rdata <= 32'h1000 + 32'(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'h1000 + ((pc >> 2) & 32'(N - 1));
  endfunction

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        een;
    logic [3:0]  eaddr;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                              input logic een, input logic [3:0] eaddr);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ein = ein;
    v.een = een; v.eaddr = eaddr;
    return v;
  endfunction

  vec_t tbl [24];

  logic [31:0] exp_pc, prev_pc, prev_in;
  int          age;
  logic        stall_prev;

  initial begin
    // Cycle 0 is the first cycle after reset release (BOOT).
    tbl[0]  = mk(1, 0, 0,     0, 0,     0,      1, 0);
    tbl[1]  = mk(1, 0, 0,     0, 0,     0,      1, 1);
    tbl[2]  = mk(1, 0, 0,     1, 32'h0, 32'h1000, 1, 2);
    tbl[3]  = mk(1, 0, 0,     1, 32'h4, 32'h1001, 1, 3);
    tbl[4]  = mk(1, 0, 0,     1, 32'h8, 32'h1002, 1, 4);
    tbl[5]  = mk(0, 0, 0,     1, 32'hC, 32'h1003, 0, 0);
    tbl[6]  = mk(0, 0, 0,     1, 32'hC, 32'h1003, 0, 0);
    tbl[7]  = mk(0, 0, 0,     1, 32'hC, 32'h1003, 0, 0);
    tbl[8]  = mk(0, 0, 0,     1, 32'hC, 32'h1003, 0, 0);
    tbl[9]  = mk(0, 0, 0,     1, 32'hC, 32'h1003, 0, 0);
    tbl[10] = mk(1, 0, 0,     1, 32'hC, 32'h1003, 1, 5);
    tbl[11] = mk(1, 0, 0,     1, 32'h10, 32'h1004, 1, 6);
    tbl[12] = mk(1, 0, 0,     1, 32'h14, 32'h1005, 1, 7);
    tbl[13] = mk(0, 1, 32'h20, 1, 32'h18, 32'h1006, 1, 8);
    tbl[14] = mk(1, 0, 0,     0, 0,     0,      1, 9);
    tbl[15] = mk(1, 0, 0,     1, 32'h20, 32'h1008, 1, 10);
    tbl[16] = mk(1, 1, 32'h10, 1, 32'h24, 32'h1009, 1, 4);
    tbl[17] = mk(1, 1, 32'h33, 0, 0,     0,      1, 12);
    tbl[18] = mk(1, 0, 0,     0, 0,     0,      1, 13);
    tbl[19] = mk(1, 0, 0,     1, 32'h30, 32'h100C, 1, 14);
    tbl[20] = mk(1, 0, 0,     1, 32'h34, 32'h100D, 1, 15);
    tbl[21] = mk(1, 0, 0,     1, 32'h38, 32'h100E, 1, 0);
    tbl[22] = mk(1, 0, 0,     1, 32'h3C, 32'h100F, 1, 1);
    tbl[23] = mk(1, 0, 0,     1, 32'h40, 32'h1000, 1, 2);

    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_en", 32'(imem_en), 0);
    chk("rst_wen", 32'(imem_wen), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      out_ready = tbl[i].rdy; redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), out_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), out_instr, tbl[i].ein);
      end
      chk($sformatf("tbl%0d_en", i), 32'(imem_en), 32'(tbl[i].een));
      if (tbl[i].een) chk($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].eaddr));
      chk($sformatf("tbl%0d_wen", i), 32'(imem_wen), 0);
      @(posedge clk); #1;
    end

    // Fill FIFO to 2, then reset for one cycle mid-stream.
    redirect_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_en", 32'(imem_en), 0);
    chk("full_pc", out_pc, 32'h44);
    chk("full_instr", out_instr, 32'h1001);
    @(posedge clk); #1;
    rst_n = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_en", 32'(imem_en), 0);
    chk("midrst_addr", 32'(imem_addr), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reboot_valid", 32'(out_valid), 0);
    chk("reboot_pc", out_pc, 0);
    chk("reboot_instr", out_instr, 0);
    chk("reboot_en", 32'(imem_en), 1);
    chk("reboot_addr", 32'(imem_addr), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reboot1_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reboot2_valid", 32'(out_valid), 1);
    chk("reboot2_pc", out_pc, 0);
    chk("reboot2_instr", out_instr, 32'h1000);
    @(posedge clk); #1;

    // Random traffic against a PC-stream model.
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_pc = 32'h0; age = 0; stall_prev = 1'b0; prev_pc = '0; prev_in = '0;
    for (int c = 0; c < 3000; c++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + $urandom_range(0, 31)
                                                   : 32'($urandom_range(0, 255));
      @(negedge clk);
      chk("rnd_wen", 32'(imem_wen), 0);
      if (rst_n) begin
        chk("rnd_valid", 32'(out_valid), 32'(age >= 2));
        if (stall_prev) begin
          chk("rnd_hold_pc", out_pc, prev_pc);
          chk("rnd_hold_instr", out_instr, prev_in);
        end
        if (out_valid && out_ready) begin
          chk("rnd_pc", out_pc, exp_pc);
          chk("rnd_instr", out_instr, instr_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
          exp_pc = {redirect_pc[31:2], 2'b00};
          age = 1;
        end else if (age < 2) begin
          age++;
        end
        stall_prev = out_valid && !out_ready && !redirect_valid;
        prev_pc = out_pc; prev_in = out_instr;
      end else begin
        chk("rnd_rst_en", 32'(imem_en), 0);
        exp_pc = 32'h0; age = 0; stall_prev = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
